// File: rtl/soc_gpio_pkg.sv
// Shared definitions for the soc_gpio peripheral: register map,
// bus FSM states and the default debounce length.
package soc_gpio_pkg;

  localparam logic [4:0] GPIO_OUT     = 5'h00;
  localparam logic [4:0] GPIO_OE      = 5'h04;
  localparam logic [4:0] GPIO_IN      = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN = 5'h0C;
  localparam logic [4:0] GPIO_FALL_EN = 5'h10;
  localparam logic [4:0] GPIO_STATUS  = 5'h14;
  localparam logic [4:0] GPIO_SET     = 5'h18;
  localparam logic [4:0] GPIO_CLR     = 5'h1C;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1024;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } bus_state_e;

endpackage

// File: rtl/soc_gpio_debounce.sv
// Single-bit debouncer: dout follows din only after din has differed
// from dout for CYCLES consecutive clocks (used under GPIO_DEBOUNCE_EN).
module gpio_debounce
  import soc_gpio_pkg::*;
#(
  parameter int unsigned CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW =
    ($clog2(CYCLES) < 1) ? 1 : $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Any cycle where din agrees with dout restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/soc_gpio.sv
// Memory-mapped GPIO with synchronised inputs, edge status and irq.
// Define GPIO_DEBOUNCE_EN to insert a per-pin gpio_debounce filter.
module soc_gpio
  import soc_gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_addr,
  input  logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  input  logic [WIDTH-1:0] gpio_ui_in,
  output logic [WIDTH-1:0] gpio_uo_out,
  output logic [WIDTH-1:0] gpio_uo_en,
  output logic             irq
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("soc_gpio: SYNC_STAGES and DEBOUNCE_CYCLES must be >= 2");
  end

  bus_state_e state;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] in_d_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] st_clr;
  logic [WIDTH-1:0] rd;
  logic [4:0]       acc_off;
  logic [4:0]       req_off;
  logic             req_we;
  logic [WIDTH-1:0] req_wdata;
  logic             unused_bits;

  assign unused_bits =
    ^{mem_addr[1:0], mem_wstrb[3:1], mem_wdata[31:WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_ui_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpio_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .din (sync_q[SYNC_STAGES-1][g]),
      .dout(s[g])
    );
  end
`else
  assign s = sync_q[SYNC_STAGES-1];
`endif

  // Edges come from the registered IN value and its previous sample.
  assign hit = (in_q & ~in_d_q & rise_en_q)
             | (~in_q & in_d_q & fall_en_q);

  assign st_clr =
    (state == ST_RESP && req_we && req_off == GPIO_STATUS)
      ? req_wdata : '0;

  assign acc_off = {mem_addr[4:2], 2'b00};

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (acc_off == GPIO_OUT):     rd = out_q;
      (acc_off == GPIO_OE):      rd = oe_q;
      (acc_off == GPIO_IN):      rd = in_q;
      (acc_off == GPIO_RISE_EN): rd = rise_en_q;
      (acc_off == GPIO_FALL_EN): rd = fall_en_q;
      (acc_off == GPIO_STATUS):  rd = status_q;
      default:                   rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      req_off   <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      in_q      <= '0;
      in_d_q    <= '0;
      irq       <= 1'b0;
    end else begin
      in_q     <= s;
      in_d_q   <= in_q;
      // A new edge beats a same-cycle write-1-to-clear.
      status_q <= (status_q & ~st_clr) | hit;
      irq      <= |(status_q & (rise_en_q | fall_en_q));
      unique case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            state     <= ST_RESP;
            mem_ready <= 1'b1;
            mem_rdata <= 32'(rd);
            req_off   <= acc_off;
            req_we    <= mem_wstrb[0];
            req_wdata <= mem_wdata[WIDTH-1:0];
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          mem_ready <= 1'b0;
          mem_rdata <= '0;
          if (req_we) begin
            unique case (1'b1)
              (req_off == GPIO_OUT):     out_q     <= req_wdata;
              (req_off == GPIO_OE):      oe_q      <= req_wdata;
              (req_off == GPIO_RISE_EN): rise_en_q <= req_wdata;
              (req_off == GPIO_FALL_EN): fall_en_q <= req_wdata;
              (req_off == GPIO_SET):     out_q     <= out_q | req_wdata;
              (req_off == GPIO_CLR):     out_q     <= out_q & ~req_wdata;
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gpio_uo_out = out_q;
  assign gpio_uo_en  = oe_q;

endmodule

// File: tb/tb_soc_gpio.sv
// Self-checking bench for soc_gpio: directed scenarios plus random
// pad/bus traffic checked against a pad-history reference model.
module tb_soc_gpio;
  import soc_gpio_pkg::*;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DC = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_ADD = DC;
`else
  localparam int DB_ADD = 0;
`endif
  localparam int LAT = S + 3 + DB_ADD;

  logic         clk;
  logic         rst;
  logic         mem_valid;
  logic         mem_ready;
  logic [4:0]   mem_addr;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic [W-1:0] gpio_ui_in;
  logic [W-1:0] gpio_uo_out;
  logic [W-1:0] gpio_uo_en;
  logic         irq;

  soc_gpio #(
    .WIDTH          (W),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .gpio_ui_in (gpio_ui_in),
    .gpio_uo_out(gpio_uo_out),
    .gpio_uo_en (gpio_uo_en),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state.
  logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_status, m_in;
  logic         m_irq;
  logic [W-1:0] pad_q [$];
  logic [W-1:0] c_q [$];
  logic         pend, pend_we;
  logic [4:0]   pend_off;
  logic [W-1:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0;
    m_status = '0; m_in = '0; m_irq = 1'b0;
    pad_q.delete();
    c_q.delete();
    repeat (64) pad_q.push_front('0);
    repeat (8) c_q.push_front('0);
  endtask

  function automatic logic [W-1:0] model_read(input logic [4:0] a);
    logic [4:0] off;
    off = {a[4:2], 2'b00};
    case (off)
      GPIO_OUT:     return m_out;
      GPIO_OE:      return m_oe;
      GPIO_IN:      return m_in;
      GPIO_RISE_EN: return m_rise;
      GPIO_FALL_EN: return m_fall;
      GPIO_STATUS:  return m_status;
      default:      return '0;
    endcase
  endfunction

  // One clock edge of the model. pad_q[k] is the pad value sampled k
  // edges ago; c_q[k] is the conditioned input ("s") k edges ago.
  task automatic model_edge();
    logic [W-1:0] c_new, cur, prv, hit, clr;
    logic irq_new;
    if (rst) begin
      model_reset();
      return;
    end
    pad_q.push_front(gpio_ui_in);
    void'(pad_q.pop_back());
`ifdef GPIO_DEBOUNCE_EN
    c_new = c_q[0];
    for (int b = 0; b < W; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int k = S; k < S + DC; k++)
        if (pad_q[k][b] == c_q[0][b]) all_diff = 1'b0;
      if (all_diff) c_new[b] = ~c_q[0][b];
    end
`else
    c_new = pad_q[S-1];
`endif
    cur = c_q[1];
    prv = c_q[2];
    hit = (cur & ~prv & m_rise) | (~cur & prv & m_fall);
    irq_new = |(m_status & (m_rise | m_fall));
    clr = '0;
    if (pend && pend_we) begin
      case ({pend_off[4:2], 2'b00})
        GPIO_OUT:     m_out = pend_data;
        GPIO_OE:      m_oe = pend_data;
        GPIO_RISE_EN: m_rise = pend_data;
        GPIO_FALL_EN: m_fall = pend_data;
        GPIO_STATUS:  clr = pend_data;
        GPIO_SET:     m_out = m_out | pend_data;
        GPIO_CLR:     m_out = m_out & ~pend_data;
        default: ;
      endcase
    end
    m_status = (m_status & ~clr) | hit;
    m_in = c_q[0];
    c_q.push_front(c_new);
    void'(c_q.pop_back());
    m_irq = irq_new;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("uo_out", 32'(gpio_uo_out), 32'(m_out));
    chk("uo_en", 32'(gpio_uo_en), 32'(m_oe));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic bus(input logic [4:0] a, input logic [3:0] st,
                     input logic [31:0] d, output logic [31:0] rd);
    logic [W-1:0] exp_rd;
    exp_rd = model_read(a);
    mem_valid = 1'b1;
    mem_addr = a;
    mem_wstrb = st;
    mem_wdata = d;
    tick();
    chk("ready_pulse", 32'(mem_ready), 32'd1);
    if (st == 4'd0) chk("rdata", mem_rdata, 32'(exp_rd));
    rd = mem_rdata;
    mem_valid = 1'b0;
    pend = 1'b1;
    pend_we = st[0];
    pend_off = a;
    pend_data = d[W-1:0];
    tick();
    pend = 1'b0;
    chk("ready_low", 32'(mem_ready), 32'd0);
    chk("rdata_idle", mem_rdata, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    rst = 1'b1;
    mem_valid = 1'b0;
    mem_addr = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    gpio_ui_in = '0;
    pend = 1'b0;
    pend_we = 1'b0;
    pend_off = '0;
    pend_data = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // Output and enable registers.
    bus(GPIO_OE, 4'h1, 32'hF0, rd);
    bus(GPIO_OUT, 4'hF, 32'hFFFF_FFA5, rd);
    tick();
    chk("t1_uo_en", 32'(gpio_uo_en), 32'hF0);
    chk("t1_uo_out", 32'(gpio_uo_out), 32'hA5);
    bus(GPIO_OUT, 4'h0, 32'h0, rd);
    chk("t1_rd_out", rd, 32'hA5);
    bus(GPIO_OE, 4'h0, 32'h0, rd);
    chk("t1_rd_oe", rd, 32'hF0);

    // SET / CLR.
    bus(GPIO_OUT, 4'h1, 32'h0F, rd);
    bus(GPIO_SET, 4'h1, 32'h30, rd);
    bus(GPIO_CLR, 4'h1, 32'h01, rd);
    chk("t2_uo_out", 32'(gpio_uo_out), 32'h3E);
    bus(GPIO_SET, 4'h0, 32'h0, rd);
    chk("t2_rd_set", rd, 32'h0);
    bus(GPIO_CLR, 4'h0, 32'h0, rd);
    chk("t2_rd_clr", rd, 32'h0);
    bus(GPIO_OUT, 4'h0, 32'h0, rd);
    chk("t2_rd_out", rd, 32'h3E);

    // Rising edge interrupt latency and W1C.
    bus(GPIO_RISE_EN, 4'h1, 32'h01, rd);
    repeat (3) tick();
    gpio_ui_in[0] = 1'b1;
    lat = 0;
    while (irq !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("t3_irq_latency", 32'(lat), 32'(LAT));
    bus(GPIO_STATUS, 4'h0, 32'h0, rd);
    chk("t3_status", rd, 32'h01);
    bus(GPIO_STATUS, 4'h1, 32'h01, rd);
    tick();
    chk("t3_irq_clear", 32'(irq), 32'd0);

    // W1C racing a newly detected fall on bit 1.
    bus(GPIO_FALL_EN, 4'h1, 32'h02, rd);
    gpio_ui_in[1] = 1'b1;
    repeat (LAT + 5) tick();
    gpio_ui_in[1] = 1'b0;
    repeat (LAT + 5) tick();
    chk("t4_irq_first", 32'(irq), 32'd1);
    gpio_ui_in[1] = 1'b1;
    repeat (LAT + 5) tick();
    gpio_ui_in[1] = 1'b0;
    repeat (2 + DB_ADD) tick();
    bus(GPIO_STATUS, 4'h1, 32'h02, rd);
    tick();
    chk("t4_irq_kept", 32'(irq), 32'd1);
    bus(GPIO_STATUS, 4'h0, 32'h0, rd);
    chk("t4_status_kept", rd & 32'h2, 32'h2);

    // Reset during an in-flight write.
    mem_valid = 1'b1;
    mem_addr = GPIO_OUT;
    mem_wstrb = 4'h1;
    mem_wdata = 32'h55;
    tick();
    chk("t5_accept", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_ready_rst", 32'(mem_ready), 32'd0);
    chk("t5_out_rst", 32'(gpio_uo_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("t5_ready_after", 32'(mem_ready), 32'd0);
    bus(GPIO_OUT, 4'h0, 32'h0, rd);
    chk("t5_rd_out", rd, 32'h0);
    chk("t5_irq", 32'(irq), 32'd0);

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch must be filtered, long level must pass.
    gpio_ui_in = '0;
    repeat (DC + 8) tick();
    gpio_ui_in[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus(GPIO_IN, 4'h0, 32'h0, rd);
      chk("t6_glitch", (rd >> 3) & 32'h1, 32'h0);
    end
    gpio_ui_in[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus(GPIO_IN, 4'h0, 32'h0, rd);
      chk("t6_glitch_after", (rd >> 3) & 32'h1, 32'h0);
    end
    gpio_ui_in[3] = 1'b1;
    for (int i = 0; i < 20; i++) bus(GPIO_IN, 4'h0, 32'h0, rd);
    chk("t6_level", (rd >> 3) & 32'h1, 32'h1);
`endif

    // Random pad activity and bus traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      logic [3:0] st;
      if ($urandom_range(0, 3) == 0)
        gpio_ui_in = gpio_ui_in ^ W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 2) == 0) begin
        tick();
      end else begin
        a = 5'($urandom_range(0, 31));
        st = ($urandom_range(0, 1) == 1) ? 4'h0
                                          : 4'($urandom_range(0, 15));
        bus(a, st, $urandom, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
